// File: rtl/right_shift_32bit_seq_pkg.sv
// Shared definitions for the sequential ALU units: FSM encodings and the
// shift-counter width helper.
package right_shift_32bit_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam int DATA_W = 32;

  // Width needed for a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/right_shift_32bit_seq.sv
// Serial right shifter: one bit position per clock, logical or arithmetic,
// with a start/busy/done handshake and a held result register.
module right_shift_32bit_seq
  import right_shift_32bit_seq_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int CW = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         arith,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] answer
);

  localparam logic [N-1:0]  AMT_MAX = N'(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fill_q, fill_d;
  logic [N-1:0]  answer_q, answer_d;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    answer_d = answer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = input2;
          // Clamp on the full-width amount so large values never alias.
          cnt_d   = (input1 >= AMT_MAX) ? CNT_MAX : input1[CW-1:0];
          fill_d  = arith & input2[N-1];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {fill_q, data_q[N-1:1]};
          cnt_d  = cnt_q - CW'(1);
        end else begin
          answer_d = data_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      fill_q   <= 1'b0;
      answer_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      answer_q <= answer_d;
    end
  end

  assign busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign answer = answer_q;

endmodule

// File: tb/tb_right_shift_32bit_seq.sv
// Scoreboard bench for the serial right shifter: expected result, start cycle
// and latency are queued at drive time and checked on each done pulse.
module tb_right_shift_32bit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic        busy, done;
  logic [31:0] answer;

  typedef struct {
    logic [31:0] ans;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_run = 0;
  logic [31:0] last_ans = '0;

  right_shift_32bit_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .arith  (arith),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .answer (answer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic ar, input logic [31:0] a1,
                                            input logic [31:0] a2);
    int amt;
    amt = (a1 >= 32) ? 32 : int'(a1);
    if (amt == 32) return (ar && a2[31]) ? 32'hFFFF_FFFF : 32'h0;
    if (ar) return $signed(a2) >>> amt;
    return a2 >> amt;
  endfunction

  function automatic int ref_lat(input logic [31:0] a1);
    return ((a1 >= 32) ? 32 : int'(a1)) + 2;
  endfunction

  // Monitor: scoreboard pop on done, result hold check while idle.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    else busy_run = 0;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("answer", answer, e.ans);
        chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        chk("busy_cycles", 32'(busy_run), 32'(e.lat));
        last_ans = e.ans;
        $display("op done: answer=%h expected=%h latency=%0d", answer, e.ans, cyc - e.start_cyc);
      end
    end else if (!busy && !reset) begin
      chk("answer_hold", answer, last_ans);
    end
  end

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic push_exp(input logic ar, input logic [31:0] a1, input logic [31:0] a2,
                          input int sc);
    exp_t e;
    e.ans = ref_shift(ar, a1, a2);
    e.start_cyc = sc;
    e.lat = ref_lat(a1);
    sb.push_back(e);
  endtask

  // One operation: start for a single cycle, then scramble operands.
  task automatic do_op(input logic ar, input logic [31:0] a1, input logic [31:0] a2);
    wait_idle();
    @(posedge clk); #1;
    arith = ar; input1 = a1; input2 = a2; start = 1'b1;
    push_exp(ar, a1, a2, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    arith = ~ar; input1 = $urandom; input2 = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n1, c0;
    logic [31:0] a2;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_answer", answer, 32'd0);

    // Directed cases, including clamped amounts.
    do_op(1'b0, 32'd4, 32'h8000_00F0);
    do_op(1'b1, 32'd4, 32'h8000_00F0);
    do_op(1'b0, 32'd0, 32'h1234_5678);
    do_op(1'b1, 32'd0, 32'h8765_4321);
    do_op(1'b0, 32'd32, 32'hFFFF_0000);
    do_op(1'b1, 32'd32, 32'h8000_0001);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    do_op(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    do_op(1'b1, 32'h0000_0020, 32'h7FFF_FFFF);
    do_op(1'b0, 32'h0000_0040, 32'hFFFF_FFFF);
    do_op(1'b1, 32'd31, 32'h8000_0000);

    // A second start mid-shift must be ignored.
    do_op(1'b0, 32'd10, 32'hA5A5_A5A5);
    repeat (3) @(posedge clk);
    #1 arith = 1'b1; input1 = 32'd2; input2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain();

    // Start held high: second op accepted in the IDLE cycle after DONE.
    wait_idle();
    n1 = 5;
    @(posedge clk); #1;
    arith = 1'b1; input1 = 32'(n1); input2 = 32'hC000_1234; start = 1'b1;
    c0 = cyc;
    push_exp(1'b1, 32'(n1), 32'hC000_1234, c0);
    @(posedge clk); #1;
    arith = 1'b0; input1 = 32'd3; input2 = 32'hF0F0_F0F0;
    push_exp(1'b0, 32'd3, 32'hF0F0_F0F0, c0 + n1 + 3);
    repeat (n1 + 3) @(posedge clk);
    #1 start = 1'b0;
    input1 = $urandom; input2 = $urandom;
    drain();

    // Reset mid-operation: no done pulse, outputs cleared.
    wait_idle();
    @(posedge clk); #1;
    arith = 1'b0; input1 = 32'd10; input2 = 32'h1357_9BDF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; last_ans = '0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_answer", answer, 32'd0);
    repeat (15) @(posedge clk);
    do_op(1'b1, 32'd7, 32'h9000_0001);

    // Random sweep.
    for (int i = 0; i < 24; i++) begin
      a2 = $urandom;
      do_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 40)), a2);
    end
    drain();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
